// File: rtl/wb_select_unit.sv
// Registered write-back selector: picks one of N_SRC sources or CONST_VAL and issues
// a single-cycle register-file write, waiting (with timeout) for slow sources.
module wb_select_unit #(
    parameter int DATA_W    = 32,
    parameter int N_SRC     = 5,
    parameter int SEL_W     = 3,
    parameter int ADDR_W    = 5,
    parameter int CONST_VAL = 227,
    parameter int TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SEL_W-1:0]        selector,
    input  logic [ADDR_W-1:0]       dest_reg,
    input  logic [N_SRC*DATA_W-1:0] data_in,
    input  logic [N_SRC-1:0]        src_valid,
    output logic                    busy,
    output logic                    reg_write,
    output logic [ADDR_W-1:0]       write_reg,
    output logic [DATA_W-1:0]       write_data,
    output logic                    err_sel,
    output logic                    err_timeout,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] CONST_EXT = DATA_W'(CONST_VAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] dest_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              reg_write_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0] write_data_q;
    logic              err_sel_q;
    logic              err_timeout_q;

    logic [SEL_W-1:0]  mux_idx;
    logic              mux_valid;
    logic [DATA_W-1:0] mux_data;
    logic              sel_bad;

    // In IDLE the live selector is looked up; while waiting, the latched one.
    always_comb begin
        mux_idx   = (state_q == S_IDLE) ? selector : sel_q;
        mux_valid = 1'b0;
        mux_data  = '0;
        if (mux_idx == SEL_W'(N_SRC)) begin
            mux_valid = 1'b1;
            mux_data  = CONST_EXT;
        end
        for (int k = 0; k < N_SRC; k++) begin
            if (mux_idx == SEL_W'(k)) begin
                mux_valid = src_valid[k];
                mux_data  = data_in[k*DATA_W +: DATA_W];
            end
        end
        sel_bad = (selector > SEL_W'(N_SRC));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            dest_q        <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            reg_write_q   <= 1'b0;
            write_reg_q   <= '0;
            write_data_q  <= '0;
            err_sel_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            reg_write_q   <= 1'b0;
            err_sel_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (sel_bad) begin
                            err_sel_q <= 1'b1;
                        end else if (mux_valid) begin
                            sel_q        <= selector;
                            dest_q       <= dest_reg;
                            write_reg_q  <= dest_reg;
                            write_data_q <= mux_data;
                            reg_write_q  <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= S_WRITE;
                        end else begin
                            sel_q   <= selector;
                            dest_q  <= dest_reg;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mux_valid) begin
                        write_reg_q  <= dest_q;
                        write_data_q <= mux_data;
                        reg_write_q  <= 1'b1;
                        state_q      <= S_WRITE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign reg_write   = reg_write_q;
    assign write_reg   = write_reg_q;
    assign write_data  = write_data_q;
    assign err_sel     = err_sel_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_wb_select_unit.sv
// Bench for wb_select_unit: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_select_unit;

    localparam int DATA_W  = 32;
    localparam int N_SRC   = 5;
    localparam int SEL_W   = 3;
    localparam int ADDR_W  = 5;
    localparam int CONSTV  = 227;
    localparam int TIMEOUT = 64;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [SEL_W-1:0]        selector = '0;
    logic [ADDR_W-1:0]       dest_reg = '0;
    logic [N_SRC*DATA_W-1:0] data_in;
    logic [N_SRC-1:0]        src_valid = '0;
    logic                    busy, reg_write, err_sel, err_timeout;
    logic [ADDR_W-1:0]       write_reg;
    logic [DATA_W-1:0]       write_data;
    logic [1:0]              dbg_state;
    logic [DATA_W-1:0]       tb_data [0:N_SRC-1];

    int checks = 0;
    int errors = 0;

    wb_select_unit #(
        .DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
        .CONST_VAL(CONSTV), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .selector(selector),
        .dest_reg(dest_reg), .data_in(data_in), .src_valid(src_valid),
        .busy(busy), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .err_sel(err_sel), .err_timeout(err_timeout),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N_SRC; k++) data_in[k*DATA_W +: DATA_W] = tb_data[k];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks one outstanding request by its start edge and the
    // first edge at which a new start may be accepted.
    int                n = 0;
    int                idle_from = 0;
    bit                pending = 0;
    int                p_src = 0;
    int                p_enter = 0;
    logic [ADDR_W-1:0] p_dest = '0;
    logic              m_rw = 0, m_es = 0, m_et = 0, m_busy = 0;
    logic [ADDR_W-1:0] m_wr = '0;
    logic [DATA_W-1:0] m_wd = '0;

    function automatic logic [DATA_W-1:0] src_word(input int s);
        if (s == N_SRC) return DATA_W'(CONSTV);
        return tb_data[s];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pending = 0; idle_from = 0; n = 0;
            m_rw = 0; m_es = 0; m_et = 0; m_busy = 0; m_wr = '0; m_wd = '0;
        end else begin
            n++;
            m_rw = 0; m_es = 0; m_et = 0;
            if (pending) begin
                if (src_valid[p_src]) begin
                    m_rw = 1; m_wr = p_dest; m_wd = src_word(p_src);
                    pending = 0; idle_from = n + 2;
                end else if (n - p_enter == TIMEOUT) begin
                    m_et = 1; pending = 0; idle_from = n + 1;
                end
            end else if (start && n >= idle_from) begin
                if (int'(selector) > N_SRC) begin
                    m_es = 1;
                end else if (int'(selector) == N_SRC || src_valid[selector]) begin
                    m_rw = 1; m_wr = dest_reg; m_wd = src_word(int'(selector));
                    idle_from = n + 2;
                end else begin
                    pending = 1; p_src = int'(selector); p_dest = dest_reg; p_enter = n;
                end
            end
            m_busy = pending || m_rw;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_busy", busy, m_busy);
            chk("m_reg_write", reg_write, m_rw);
            chk("m_err_sel", err_sel, m_es);
            chk("m_err_timeout", err_timeout, m_et);
            chk("m_write_reg", write_reg, m_wr);
            chk("m_write_data", write_data, m_wd);
        end
    end

    task automatic drive(input logic st, input int sel, input int dest, input logic [N_SRC-1:0] v);
        start = st; selector = SEL_W'(sel); dest_reg = ADDR_W'(dest); src_valid = v;
    endtask

    initial begin
        for (int k = 0; k < N_SRC; k++) tb_data[k] = DATA_W'(32'h100 * (k + 1));
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_write_data", write_data, '0);
        reset = 1'b0;

        // Immediate write from a ready source
        @(negedge clk);
        tb_data[0] = 32'h1234;
        drive(1, 0, 8, 5'b00001);
        @(negedge clk);
        chk("t1_rw", reg_write, 1'b1);
        chk("t1_wr", write_reg, 5'd8);
        chk("t1_wd", write_data, 32'h1234);
        chk("t1_busy", busy, 1'b1);
        drive(0, 0, 0, 5'b00000);
        @(negedge clk);
        chk("t1_busy_drop", busy, 1'b0);
        chk("t1_rw_drop", reg_write, 1'b0);
        chk("t1_wd_hold", write_data, 32'h1234);

        // Constant source
        drive(1, 5, 31, 5'b00000);
        @(negedge clk);
        chk("t2_rw", reg_write, 1'b1);
        chk("t2_wr", write_reg, 5'd31);
        chk("t2_wd", write_data, 32'd227);
        drive(0, 0, 0, 5'b00000);
        @(negedge clk);

        // Slow source, ignored starts while waiting and in the write cycle
        tb_data[3] = 32'h0;
        drive(1, 3, 5, 5'b00001);
        @(negedge clk);
        chk("t3_busy", busy, 1'b1);
        chk("t3_rw0", reg_write, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive((i % 2) == 0, 0, 12, 5'b00001);
            @(negedge clk);
            chk("t3_no_write", reg_write, 1'b0);
        end
        tb_data[3] = 32'hDEAD;
        drive(0, 0, 0, 5'b01000);
        @(negedge clk);
        chk("t3_rw", reg_write, 1'b1);
        chk("t3_wr", write_reg, 5'd5);
        chk("t3_wd", write_data, 32'hDEAD);
        tb_data[3] = 32'hBEEF;
        drive(1, 0, 12, 5'b01001);
        @(negedge clk);
        chk("t3_rw_end", reg_write, 1'b0);
        chk("t3_busy_end", busy, 1'b0);
        chk("t3_wd_hold", write_data, 32'hDEAD);
        drive(0, 0, 0, 5'b00000);
        @(negedge clk);
        chk("t3_late_start_ignored", reg_write, 1'b0);

        // Timeout
        drive(1, 4, 9, 5'b00001);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 0, 0, 5'b00001);
            chk("t4_no_err_yet", err_timeout, 1'b0);
        end
        @(negedge clk);
        chk("t4_err", err_timeout, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_rw", reg_write, 1'b0);
        @(negedge clk);
        chk("t4_err_pulse", err_timeout, 1'b0);

        // Bad selectors
        drive(1, 6, 3, 5'b11111);
        @(negedge clk);
        chk("t5_err6", err_sel, 1'b1);
        chk("t5_busy6", busy, 1'b0);
        drive(0, 0, 0, 5'b00000);
        @(negedge clk);
        chk("t5_err_pulse", err_sel, 1'b0);
        drive(1, 7, 3, 5'b11111);
        @(negedge clk);
        chk("t5_err7", err_sel, 1'b1);
        chk("t5_rw7", reg_write, 1'b0);
        drive(0, 0, 0, 5'b00000);
        @(negedge clk);

        // dest_reg 0 still strobes
        tb_data[1] = 32'hCAFE_0001;
        drive(1, 1, 0, 5'b00010);
        @(negedge clk);
        chk("t7_rw_zero", reg_write, 1'b1);
        chk("t7_wr_zero", write_reg, 5'd0);
        chk("t7_wd", write_data, 32'hCAFE_0001);
        drive(0, 0, 0, 5'b00000);
        @(negedge clk);

        // Asynchronous reset mid-wait
        drive(1, 2, 7, 5'b00000);
        @(negedge clk);
        drive(0, 0, 0, 5'b00000);
        repeat (3) @(negedge clk);
        chk("t6_busy_before", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_wr_rst", write_reg, '0);
        chk("t6_wd_rst", write_data, '0);
        @(negedge clk);
        #1 reset = 1'b0;
        tb_data[2] = 32'h5555;
        src_valid = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_write", reg_write, 1'b0);
            chk("t6_idle", busy, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
